activation_stream: RTL

ACTIVATION_STREAM -- requirements
Module: activation_stream

---
 rtl/act_pkg.sv | 14 +
 rtl/act_lane.sv | 99 +++++++++
 rtl/activation_stream.sv | 120 ++++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// Shared definitions for the activation output stream.
// Holds mode encodings and the saturation counter width.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_LINEAR = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CLIP   = 2'd3
  } act_mode_e;

  localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/act_lane.sv
// One lane of the activation datapath: stage 1 applies the activation at full
// accumulator precision; stage 2 rounds, rescales, saturates and clips.
// Ports: clk, rst_n, s1_en/s2_en (stage loads), acc_in (accumulator),
// in_mode (mode of incoming beat), s1_mode/s1_clip (stage-1 sideband),
// y (result), sat (clamped flag).
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_SZ     = 12,
  parameter int ACC_FRAC    = 12,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s1_en,
  input  logic                    s2_en,
  input  logic [2*DATA_WIDTH-1:0] acc_in,
  input  act_mode_e               in_mode,
  input  act_mode_e               s1_mode,
  input  logic [DATA_WIDTH-1:0]   s1_clip,
  output logic [DATA_WIDTH-1:0]   y,
  output logic                    sat
);

  localparam int AW  = 2 * DATA_WIDTH;
  localparam int SH  = ACC_FRAC - FRAC_SZ;
  localparam int RSH = (SH > 0) ? SH - 1 : 0;

  localparam logic signed [AW:0] RND =
    (SH > 0) ? ((AW+1)'(1) <<< RSH) : '0;
  localparam logic signed [AW:0] MAXV =
    {{(AW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW:0] MINV =
    {{(AW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [AW-1:0] x;
  logic signed [AW-1:0] act_d, act_q;
  logic signed [AW:0]   wide;
  logic signed [AW:0]   shv;
  logic [DATA_WIDTH-1:0] sv;
  logic                  sf;
  logic [DATA_WIDTH-1:0] y_d, y_q;
  logic                  sat_d, sat_q;

  assign x = $signed(acc_in);

  always_comb begin
    act_d = act_q;
    if (s1_en) begin
      case (in_mode)
        ACT_LINEAR: act_d = x;
        ACT_RELU:   act_d = x[AW-1] ? '0 : x;
        ACT_LEAKY:  act_d = x[AW-1] ? (x >>> LEAKY_SHIFT) : x;
        ACT_CLIP:   act_d = x[AW-1] ? '0 : x;
        default:    act_d = x;
      endcase
    end
  end

  // One extra bit of headroom so the rounding add cannot wrap.
  always_comb begin
    wide = {act_q[AW-1], act_q} + RND;
    shv  = wide >>> SH;
    sf   = 1'b0;
    if (shv > MAXV) begin
      sv = MAXV[DATA_WIDTH-1:0];
      sf = 1'b1;
    end else if (shv < MINV) begin
      sv = MINV[DATA_WIDTH-1:0];
      sf = 1'b1;
    end else begin
      sv = shv[DATA_WIDTH-1:0];
    end
    if (s1_mode == ACT_CLIP &&
        $signed(sv) > $signed(s1_clip)) begin
      sv = s1_clip;
      sf = 1'b1;
    end
    y_d   = s2_en ? sv : y_q;
    sat_d = s2_en ? sf : sat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      act_q <= act_d;
      y_q   <= y_d;
      sat_q <= sat_d;
    end
  end

  assign y   = y_q;
  assign sat = sat_q;

endmodule

// File: rtl/activation_stream.sv
// Two-stage valid/ready activation pipeline over LANES accumulator lanes.
// Ports: in_* upstream beat, out_* downstream beat, mode/clip_val per beat,
// sat_count/sat_clr saturation statistics.
module activation_stream
  import act_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_SZ     = 12,
  parameter int ACC_FRAC    = 12,
  parameter int LANES       = 4,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*2*DATA_WIDTH-1:0] in_data,
  input  logic                          in_last,
  input  logic [1:0]                    mode,
  input  logic [DATA_WIDTH-1:0]         clip_val,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic                          out_last,
  output logic [LANES-1:0]              out_sat,
  output logic [SAT_CNT_W-1:0]          sat_count,
  input  logic                          sat_clr
);

  localparam int AW = 2 * DATA_WIDTH;

  logic                  s1_valid_d, s1_valid_q;
  logic                  s2_valid_d, s2_valid_q;
  act_mode_e             s1_mode_d, s1_mode_q;
  logic [DATA_WIDTH-1:0] s1_clip_d, s1_clip_q;
  logic                  s1_last_d, s1_last_q;
  logic                  s2_last_d, s2_last_q;
  logic [SAT_CNT_W-1:0]  sat_cnt_d, sat_cnt_q;
  logic                  s1_en, s2_en, out_fire;

  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
  assign s1_en    = in_valid && in_ready;
  assign s2_en    = s1_valid_q && (!s2_valid_q || out_ready);
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_clip_d  = s1_clip_q;
    s1_last_d  = s1_last_q;
    s2_last_d  = s2_last_q;
    sat_cnt_d  = sat_cnt_q;
    if (s1_en) begin
      s1_valid_d = 1'b1;
      s1_mode_d  = act_mode_e'(mode);
      s1_clip_d  = clip_val;
      s1_last_d  = in_last;
    end else if (s2_en) begin
      s1_valid_d = 1'b0;
    end
    if (s2_en) begin
      s2_valid_d = 1'b1;
      s2_last_d  = s1_last_q;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (out_fire && |out_sat &&
                 sat_cnt_q != '1) begin
      sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_mode_q  <= ACT_LINEAR;
      s1_clip_q  <= '0;
      s1_last_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_clip_q  <= s1_clip_d;
      s1_last_q  <= s1_last_d;
      s2_last_q  <= s2_last_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_SZ    (FRAC_SZ),
      .ACC_FRAC   (ACC_FRAC),
      .LEAKY_SHIFT(LEAKY_SHIFT)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .s1_en  (s1_en),
      .s2_en  (s2_en),
      .acc_in (in_data[g*AW +: AW]),
      .in_mode(act_mode_e'(mode)),
      .s1_mode(s1_mode_q),
      .s1_clip(s1_clip_q),
      .y      (out_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .sat    (out_sat[g])
    );
  end

  assign out_valid = s2_valid_q;
  assign out_last  = s2_last_q;
  assign sat_count = sat_cnt_q;

endmodule
